// File: rtl/rib_arb_pkg.sv
// Shared constants and types for the RIB bus arbiter: master indices,
// default sizing, the fixed priority order and the lock state encoding.
package rib_arb_pkg;

  localparam int NUM_M    = 4;
  localparam int AGE_MAX  = 8;
  localparam int AGE_W    = 4;
  localparam int LOCK_MAX = 16;

  localparam logic [1:0] M_EX   = 2'd0;
  localparam logic [1:0] M_PC   = 2'd1;
  localparam logic [1:0] M_JTAG = 2'd2;
  localparam logic [1:0] M_UART = 2'd3;

  // Entry 0 is the highest priority.
  localparam logic [1:0] PRIO_ORDER [NUM_M] = '{M_UART, M_JTAG, M_EX, M_PC};

  typedef enum logic [0:0] {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rib_arb_age_cnt.sv
// Saturating starvation counter for one master; aged flags a requester that
// has lost arbitration AGE_MAX cycles in a row.
module rib_arb_age_cnt #(
  parameter int AGE_MAX = 8,
  parameter int AGE_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  input  logic clr,
  output logic aged
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0] age_r;

  // Count losing cycles, saturating; any grant or idle cycle restarts aging.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      age_r <= '0;
    end else if (req && !gnt) begin
      if (age_r != AGE_SAT) begin
        age_r <= age_r + 1'b1;
      end else begin
        age_r <= age_r;
      end
    end else begin
      age_r <= '0;
    end
  end

  assign aged = (age_r == AGE_SAT);

endmodule

// File: rtl/rib_arbiter.sv
// Grant controller for the 4-master RIB bus: fixed priority with starvation
// aging and a bounded bus lock; hold_flag_o stalls fetch when it lacks the bus.
module rib_arbiter #(
  parameter int NUM_M    = rib_arb_pkg::NUM_M,
  parameter int AGE_MAX  = rib_arb_pkg::AGE_MAX,
  parameter int AGE_W    = rib_arb_pkg::AGE_W,
  parameter int LOCK_MAX = rib_arb_pkg::LOCK_MAX,
  parameter int PC_M     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req_i,
  input  logic [NUM_M-1:0] lock_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [1:0]       gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             hold_flag_o,
  output logic             lock_ovf_o
);

  import rib_arb_pkg::*;

  localparam int              CNT_W   = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  lock_state_e      state_r, state_nxt_s;
  logic [1:0]       lock_own_r, lock_own_nxt_s;
  logic [CNT_W-1:0] lock_cnt_r, lock_cnt_nxt_s;

  logic             owner_locking_s, lock_hold_s, lock_ovf_s, acquire_s;
  logic [1:0]       sel_idx_s;
  logic             sel_valid_s;
  logic [NUM_M-1:0] aged_s;

  assign owner_locking_s = (state_r == LK_LOCKED) && req_i[lock_own_r] && lock_i[lock_own_r];
  assign lock_hold_s     = owner_locking_s && (lock_cnt_r != CNT_MAX);
  assign lock_ovf_s      = owner_locking_s && (lock_cnt_r == CNT_MAX);
  // A force-released owner may not grab the lock again at the same edge.
  assign acquire_s       = sel_valid_s && !lock_hold_s && lock_i[sel_idx_s] &&
                           !(lock_ovf_s && (sel_idx_s == lock_own_r));

  for (genvar m = 0; m < NUM_M; m++) begin : g_age
    rib_arb_age_cnt #(.AGE_MAX(AGE_MAX), .AGE_W(AGE_W)) u_age (
      .clk  (clk),
      .rst  (rst),
      .req  (req_i[m]),
      .gnt  (gnt_o[m]),
      .clr  (lock_ovf_s && (lock_own_r == 2'(m))),
      .aged (aged_s[m])
    );
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= LK_UNLOCKED;
      lock_own_r <= 2'd0;
      lock_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      lock_own_r <= lock_own_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
    end
  end

  // Lock next-state: extend, hand over to a new locker, or release.
  always_comb begin
    state_nxt_s    = state_r;
    lock_own_nxt_s = lock_own_r;
    lock_cnt_nxt_s = lock_cnt_r;
    case (state_r)
      LK_LOCKED, LK_UNLOCKED: begin
        if (lock_hold_s) begin
          state_nxt_s    = LK_LOCKED;
          lock_cnt_nxt_s = lock_cnt_r + 1'b1;
        end else if (acquire_s) begin
          state_nxt_s    = LK_LOCKED;
          lock_own_nxt_s = sel_idx_s;
          lock_cnt_nxt_s = CNT_W'(1);
        end else begin
          state_nxt_s    = LK_UNLOCKED;
          lock_cnt_nxt_s = '0;
        end
      end
      default: begin
        state_nxt_s    = LK_UNLOCKED;
        lock_cnt_nxt_s = '0;
      end
    endcase
  end

  // Grant select: held lock, then lowest aged index, then fixed priority.
  always_comb begin
    sel_idx_s   = 2'd0;
    sel_valid_s = 1'b0;
    if (lock_hold_s) begin
      sel_idx_s   = lock_own_r;
      sel_valid_s = 1'b1;
    end else if (|(aged_s & req_i)) begin
      for (int i = NUM_M - 1; i >= 0; i--) begin
        if (aged_s[i] && req_i[i]) begin
          sel_idx_s   = 2'(i);
          sel_valid_s = 1'b1;
        end
      end
    end else begin
      for (int p = NUM_M - 1; p >= 0; p--) begin
        if (req_i[PRIO_ORDER[p]]) begin
          sel_idx_s   = PRIO_ORDER[p];
          sel_valid_s = 1'b1;
        end
      end
    end
  end

  // Bus-facing outputs, all silenced while reset is asserted.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = sel_valid_s && !rst;
    gnt_idx_o   = 2'd0;
    if (gnt_valid_o) begin
      gnt_idx_o        = sel_idx_s;
      gnt_o[sel_idx_s] = 1'b1;
    end else begin
      gnt_idx_o = 2'd0;
    end
    hold_flag_o = gnt_valid_o && (gnt_idx_o != 2'(PC_M));
    lock_ovf_o  = lock_ovf_s && !rst;
  end

endmodule
